// File: rtl/ysyx_220578_wbu_regfile_pkg.sv
// Shared ysyx_220578 core constants: register file geometry plus the
// opcode/func3 encodings used across the pipeline.
package ysyx_220578_wbu_regfile_pkg;

  localparam int YSYX_ADDR_WIDTH   = 5;
  localparam int YSYX_DATA_WIDTH   = 64;
  localparam int YSYX_REG_NUM      = 32;
  localparam int YSYX_WB_BUF_DEPTH = 2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/ysyx_220578_wbu_regfile_wb_fifo.sv
// In-order write buffer between EXU and the register array, with a
// youngest-match lookup so pending writes can be forwarded to readers.
module ysyx_220578_wb_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic                  rd1_hit,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic                  rd2_hit,
  output logic [DATA_WIDTH-1:0] rd2_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [PTR_W:0]        count_r;
  logic [PTR_W-1:0]      idx_s;
  logic                  live_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign head_addr = addr_mem_r[head_r];
  assign head_data = data_mem_r[head_r];

  // Entry storage, pointers and occupancy; push is never issued when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_WIDTH{1'b0}};
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push) begin
        addr_mem_r[tail_r] <= push_addr;
        data_mem_r[tail_r] <= push_data;
        tail_r             <= tail_r + PTR_ONE;
      end
      if (pop) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Walk oldest to youngest so the last live match wins.
  always_comb begin
    rd1_hit  = 1'b0;
    rd1_data = {DATA_WIDTH{1'b0}};
    rd2_hit  = 1'b0;
    rd2_data = {DATA_WIDTH{1'b0}};
    idx_s    = head_r;
    live_s   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s    = head_r + k[PTR_W-1:0];
      live_s   = (k[PTR_W:0] < count_r);
      rd1_data = (live_s && addr_mem_r[idx_s] == rd1_addr) ? data_mem_r[idx_s] : rd1_data;
      rd1_hit  = rd1_hit | (live_s && addr_mem_r[idx_s] == rd1_addr);
      rd2_data = (live_s && addr_mem_r[idx_s] == rd2_addr) ? data_mem_r[idx_s] : rd2_data;
      rd2_hit  = rd2_hit | (live_s && addr_mem_r[idx_s] == rd2_addr);
    end
  end

endmodule

// File: rtl/ysyx_220578_wbu_regfile.sv
// Write-back unit: buffers EXU results, retires one per cycle into the
// integer register array, and serves two forwarded read ports.
module ysyx_220578_wbu_regfile
  import ysyx_220578_wbu_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = YSYX_ADDR_WIDTH,
  parameter int DATA_WIDTH = YSYX_DATA_WIDTH,
  parameter int BUF_DEPTH  = YSYX_WB_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  commit_stall,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  commit_valid,
  output logic [ADDR_WIDTH-1:0] commit_addr,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic                  buf_empty
);

  localparam int REG_NUM = int'(32'd1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_r [REG_NUM];
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  hit1_s;
  logic                  hit2_s;
  logic [DATA_WIDTH-1:0] fwd1_s;
  logic [DATA_WIDTH-1:0] fwd2_s;
  logic                  push_s;
  logic                  pop_s;

  // x0 writes complete the handshake but never occupy the buffer.
  assign wb_ready  = ~fifo_full_s;
  assign buf_empty = fifo_empty_s;
  assign push_s    = wb_valid & ~fifo_full_s & (wb_addr != ZERO_ADDR);
  assign pop_s     = ~fifo_empty_s & ~commit_stall;

  ysyx_220578_wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_addr (wb_addr),
    .push_data (wb_data),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .rd1_addr  (rs1_addr),
    .rd2_addr  (rs2_addr),
    .rd1_hit   (hit1_s),
    .rd1_data  (fwd1_s),
    .rd2_hit   (hit2_s),
    .rd2_data  (fwd2_s)
  );

  // Architectural register array, written from the buffer head on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (pop_s) begin
      regs_r[head_addr_s] <= head_data_s;
    end
  end

  // Retirement report; address and data hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_addr  <= ZERO_ADDR;
      commit_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      commit_valid <= pop_s;
      if (pop_s) begin
        commit_addr <= head_addr_s;
        commit_data <= head_data_s;
      end
    end
  end

  // Operand reads: x0 is hardwired, then pending writes, then the array.
  always_comb begin
    rs1_data = {DATA_WIDTH{1'b0}};
    rs2_data = {DATA_WIDTH{1'b0}};
    if (rs1_addr == ZERO_ADDR) begin
      rs1_data = {DATA_WIDTH{1'b0}};
    end else if (hit1_s) begin
      rs1_data = fwd1_s;
    end else begin
      rs1_data = regs_r[rs1_addr];
    end
    if (rs2_addr == ZERO_ADDR) begin
      rs2_data = {DATA_WIDTH{1'b0}};
    end else if (hit2_s) begin
      rs2_data = fwd2_s;
    end else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

endmodule

// File: tb/tb_ysyx_220578_wbu_regfile.sv
// Randomised scoreboard bench for the write-back unit and register file.
module tb_ysyx_220578_wbu_regfile;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        commit_stall;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        commit_valid;
  logic [4:0]  commit_addr;
  logic [63:0] commit_data;
  logic        buf_empty;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] ref_regs [32];
  ent_t        pend[$];
  ent_t        expq[$];
  logic        exp_cv;

  ysyx_220578_wbu_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .commit_stall (commit_stall),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data),
    .buf_empty    (buf_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].a == a) return pend[i].d;
    end
    return ref_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ref_regs[i] = 64'd0;
    pend.delete();
    expq.delete();
    exp_cv = 1'b0;
  endtask

  // One cycle: drive just after a negedge, check, model the edge, return at next negedge.
  task automatic step(input logic v, input logic [4:0] a, input logic [63:0] d,
                      input logic stall, input logic [4:0] r1, input logic [4:0] r2);
    logic acc;
    ent_t e;
    wb_valid = v; wb_addr = a; wb_data = d; commit_stall = stall;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    check("wb_ready", {63'd0, wb_ready}, {63'd0, pend.size() < 2});
    check("buf_empty", {63'd0, buf_empty}, {63'd0, pend.size() == 0});
    check("commit_valid", {63'd0, commit_valid}, {63'd0, exp_cv});
    check("rs1_data", rs1_data, model_read(r1));
    check("rs2_data", rs2_data, model_read(r2));
    @(posedge clk);
    acc = v && (pend.size() < 2);
    if (pend.size() > 0 && !stall) begin
      ref_regs[pend[0].a] = pend[0].d;
      void'(pend.pop_front());
      exp_cv = 1'b1;
    end else begin
      exp_cv = 1'b0;
    end
    if (acc && a != 5'd0) begin
      e.a = a; e.d = d;
      pend.push_back(e);
      expq.push_back(e);
    end
    @(negedge clk);
  endtask

  // Monitor: every retirement pulse must match the oldest expected write.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && commit_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_commit", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          check("commit_addr", {59'd0, commit_addr}, {59'd0, e.a});
          check("commit_data", commit_data, e.d);
        end
      end
    end
  end

  initial begin
    logic [4:0] ra;
    rst = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
    commit_stall = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_commit_addr", {59'd0, commit_addr}, 64'd0);
    check("rst_commit_data", commit_data, 64'd0);
    rst = 1'b0;

    for (int i = 1; i < 32; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'(i), 5'(32 - i));

    // Forwarding then retirement of a single write
    step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd5, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 5'd5);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 5'd0);

    // Stalled buffer: youngest wins, full refuses, in-order drain
    step(1'b1, 5'd3, 64'hA, 1'b1, 5'd0, 5'd3);
    step(1'b1, 5'd3, 64'hB, 1'b1, 5'd0, 5'd3);
    step(1'b1, 5'd3, 64'hC, 1'b1, 5'd3, 5'd3);
    step(1'b1, 5'd4, 64'hD, 1'b0, 5'd3, 5'd3);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 5'd4);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 5'd4);

    // x0 write is swallowed
    step(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);

    // Back-to-back sustained writes
    for (int i = 1; i <= 8; i++) step(1'b1, 5'(i), 64'(16 * i), 1'b0, 5'(i), 5'(i - 1));
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd8, 5'd7);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd1, 5'd2);

    // Reset mid-stall with two pending writes
    step(1'b1, 5'd3, 64'h77, 1'b1, 5'd3, 5'd0);
    step(1'b1, 5'd6, 64'h88, 1'b1, 5'd3, 5'd6);
    wb_valid = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd6;
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_async_empty", {63'd0, buf_empty}, 64'd1);
    check("rst_async_ready", {63'd0, wb_ready}, 64'd1);
    check("rst_async_cv", {63'd0, commit_valid}, 64'd0);
    check("rst_async_x3", rs1_data, 64'd0);
    check("rst_async_x6", rs2_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 5'd6);

    // Random traffic, addresses biased low to provoke collisions
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, ra, {$urandom, $urandom}, $urandom_range(0, 9) < 4,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'(i), 5'(i + 4));
    for (int i = 1; i < 32; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'(i), 5'(31 - i));
    check("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_220578_wbu_regfile.md
# ysyx_220578_wbu_regfile

Write-back unit and integer register file for the ysyx_220578 core. Accepts result writes from the EXU over a valid/ready port and holds them in a 2-entry in-order write buffer. Drains one buffered write per cycle into a 32×64 architectural register array. Provides two combinational operand read ports to the IDU, with forwarding from buffered-but-uncommitted writes.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 64, register data width
- BUF_DEPTH, 2, write-buffer entries (power of two, ≥2)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  EXU presents a write (driven from EXU rd_wen)
- wb_ready  out  1  buffer can accept this cycle
- wb_addr  in  ADDR_WIDTH  destination register index
- wb_data  in  DATA_WIDTH  destination data
- commit_stall  in  1  inhibits draining the buffer this cycle
- rs1_addr, rs2_addr  in  ADDR_WIDTH  read indices
- rs1_data, rs2_data  out  DATA_WIDTH  read data (combinational)
- commit_valid  out  1  registered pulse: one write retired into the array last edge
- commit_addr  out  ADDR_WIDTH  index of that write
- commit_data  out  DATA_WIDTH  data of that write
- buf_empty  out  1  no pending writes

## Operation
- Reset: array all zero, buffer empty, wb_ready=1, buf_empty=1, commit_valid=0, commit_addr=0, commit_data=0.
- Accept: wb_valid && wb_ready at an edge enqueues {addr,data} at the tail.
- wb_addr==0 with wb_valid && wb_ready: the handshake completes and the write is discarded, not enqueued.
- wb_ready = (count < BUF_DEPTH). It depends only on the current count, not on same-cycle drain, so a full buffer refuses even while draining.
- Drain: when count>0 and !commit_stall, the head entry is written into the array and dequeued at the edge. commit_valid/addr/data are registered from that entry; otherwise commit_valid=0 and addr/data hold.
- Simultaneous enqueue and dequeue: count unchanged; pointers both advance modulo BUF_DEPTH.
- Reads: index 0 returns 0. Otherwise the youngest buffered entry with matching addr supplies data; if none matches, the array supplies data. rs1 and rs2 resolve independently.
- Same-cycle incoming wb_data is NOT forwarded to reads; it is visible only from the next cycle.
- Reset asserted mid-operation: buffered writes are lost, array cleared, outputs return to reset values immediately (asynchronous).

## Timing
- Write accepted at edge N → visible on read ports from cycle N+1 via forwarding.
- Unstalled: written into the array at edge N+1, commit_valid high during cycle N+1→N+2.
- Throughput: one write per cycle sustained with commit_stall=0; buffer never exceeds one entry in that case.
- With commit_stall held: two writes accepted, then wb_ready=0 until a drain edge.
- buf_empty = (count==0), combinational from registered state.

## Structure
- Shared package/defines: ysyx_220578 width constants (ADDR/DATA) and register-count constant 32, alongside the existing opcode/func3 defines.
- One sub-module: ysyx_220578_wb_fifo (pointers, count, entry storage, head output, CAM-style youngest-match lookup for two read indices). Top holds the array, x0 handling, and commit registers.

## Test plan
- Reset then read x1..x31 → all 0; wb_ready=1, buf_empty=1, commit_valid=0.
- Write x5=0x1234 at edge N, commit_stall=0 → rs1_data(x5)=0x1234 in cycle N+1; commit_valid=1, commit_addr=5, commit_data=0x1234 after edge N+1.
- commit_stall=1, write x3=0xA then x3=0xB → rs2_data(x3)=0xB (youngest wins); third write sees wb_ready=0; release stall → commits in order 0xA then 0xB; array holds x3=0xB.
- Write x0=0xFFFF → accepted, no commit pulse, rs1_data(x0)=0, buf_empty stays 1.
- Back-to-back writes x1..x8 (values 0x10·i) with stall=0 → 8 consecutive commit pulses, wb_ready never drops.
- Stall with 2 pending entries, assert rst for one cycle mid-stall → buffer empty, x3 reads 0, commit_valid=0 immediately.
